// File: rtl/imem_loader_pkg.sv
// Shared constants for the IMEM stream loader: state encoding and byte-lane sizing.
package imem_loader_pkg;

    // Header is one little-endian 32-bit word count
    localparam int HDR_BYTES  = 4;
    // Bytes per instruction word, i.e. number of byte lanes
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    // Loader state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/imem_stream_loader_packer.sv
// Byte-to-word packer: 2-bit lane counter plus little-endian shift-in register.
// word/word_valid are combinational so the word completing on the 4th byte is
// visible in the same cycle as that byte's transfer.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [LANE_W-1:0] lane;
    logic [31:0]       shift_q;

    // First byte of a word ends up in bits [7:0] after four shifts
    assign word       = {byte_in, shift_q[31:8]};
    assign word_valid = accept && (lane == LANE_W'(WORD_BYTES - 1));

    // Lane counter and assembly register; clear wins over a concurrent byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane    <= '0;
            shift_q <= '0;
        end else if (clear) begin
            lane    <= '0;
            shift_q <= '0;
        end else if (accept) begin
            lane    <= lane + 1'b1;
            shift_q <= word;
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot-time program loader: header word N then N little-endian words written
// to IMEM; holds the core in reset until the whole image is written.
// Stream handshake: a byte transfers on a rising edge where s_valid && s_ready;
// s_ready does not depend on s_valid, and bytes offered while s_ready is low
// stay with the source.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] n_words;
    logic             accept;
    logic             start_arm;
    logic             word_valid;
    logic [31:0]      word;
    logic             last_word;

    assign accept    = s_valid && s_ready;
    // start only counts where a new load may begin; it is ignored mid-load
    assign start_arm = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign last_word = (word_idx + 1'b1) == n_words;

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_arm),
        .accept     (accept),
        .byte_in    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (word_valid) begin
                    if (word == 32'd0)                     state_nxt = ST_DONE;
                    else if (word > 32'(DEPTH_WORDS))      state_nxt = ST_ERR;
                    else                                   state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and status outputs, all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= state_nxt;
            s_ready    <= (state_nxt == ST_HDR) || (state_nxt == ST_DATA);
            busy       <= (state_nxt == ST_HDR) || (state_nxt == ST_DATA);
            done       <= (state_nxt == ST_DONE);
            err        <= (state_nxt == ST_ERR);
            // Release one cycle after entering DONE, so after the last write
            core_rst_n <= (state == ST_DONE) && (state_nxt == ST_DONE);
        end
    end

    // Word counters and the IMEM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            word_idx     <= '0;
            n_words      <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_arm) begin
                word_idx     <= '0;
                words_loaded <= '0;
            end
            if (state == ST_HDR && word_valid) begin
                n_words  <= word[CNT_W-1:0];
                word_idx <= '0;
            end
            if (state == ST_DATA && word_valid) begin
                imem_we      <= 1'b1;
                imem_addr    <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
                imem_wdata   <= word;
                word_idx     <= word_idx + 1'b1;
                words_loaded <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: byte driver, write scoreboard
// keyed on {address, data}, and directed status checks around each load.
module tb_imem_stream_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] BASE = 32'h0000_0000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] words_loaded;

    logic [63:0] exp_q[$];
    int total;
    int bad;
    int n_writes;

    imem_stream_loader #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write must match the oldest expected {addr, data}
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic expect_write(input int k, input logic [31:0] w);
        logic [AW-1:0] a;
        a = BASE + AW'(k * 4);
        exp_q.push_back({a, w});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte; returns at the negedge after it transferred
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    // Checks at the negedge right after the final transfer of a good image
    task automatic check_finish(input string tag, input int nw);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_rst_hold"}, 64'(core_rst_n), 64'd0);
        check({tag, "_ready_drop"}, 64'(s_ready), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'(nw));
        @(negedge clk);
        check({tag, "_rst_rel"}, 64'(core_rst_n), 64'd1);
        check({tag, "_no_we"}, 64'(imem_we), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] prog [3];
    int writes_before;

    initial begin
        total = 0; bad = 0; n_writes = 0;
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0000_006F;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_core", 64'(core_rst_n), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(BASE));
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        rst_n = 1'b1;

        // idle with bytes offered: nothing consumed
        s_valid = 1'b1; s_data = 8'hAA;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;

        // normal load
        for (int k = 0; k < 3; k++) expect_write(k, prog[k]);
        pulse_start();
        check("hdr_busy", 64'(busy), 64'd1);
        check("hdr_ready", 64'(s_ready), 64'd1);
        send_word(32'd3, 1'b0);
        for (int k = 0; k < 3; k++) send_word(prog[k], 1'b0);
        check_finish("load", 3);

        // reload from DONE with random valid gaps
        pulse_start();
        check("reload_core", 64'(core_rst_n), 64'd0);
        check("reload_busy", 64'(busy), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        for (int k = 0; k < 3; k++) expect_write(k, prog[k]);
        send_word(32'd3, 1'b1);
        for (int k = 0; k < 3; k++) send_word(prog[k], 1'b1);
        check_finish("gaps", 3);

        // empty header
        writes_before = n_writes;
        pulse_start();
        send_word(32'd0, 1'b0);
        check_finish("empty", 0);
        check("empty_no_write", 64'(n_writes), 64'(writes_before));

        // oversize header, then bytes offered while in ERR
        pulse_start();
        send_word(32'(DEPTH + 1), 1'b0);
        s_valid = 1'b1; s_data = 8'h55;
        for (int i = 0; i < 6; i++) begin
            check("err_flag", 64'(err), 64'd1);
            check("err_ready", 64'(s_ready), 64'd0);
            check("err_core", 64'(core_rst_n), 64'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("err_no_write", 64'(n_writes), 64'(writes_before));

        // one-word image from ERR
        expect_write(0, 32'h0000_0137);
        pulse_start();
        check("err_exit_flag", 64'(err), 64'd0);
        send_word(32'd1, 1'b0);
        send_word(32'h0000_0137, 1'b0);
        check_finish("one", 1);

        // async abort after 6 payload bytes
        expect_write(0, prog[0]);
        pulse_start();
        send_word(32'd3, 1'b0);
        send_word(prog[0], 1'b0);
        send_byte(prog[1][7:0], 1'b0);
        send_byte(prog[1][15:8], 1'b0);
        writes_before = n_writes;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(s_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_words", 64'(words_loaded), 64'd0);
        check("abort_core", 64'(core_rst_n), 64'd0);
        s_valid = 1'b1; s_data = 8'h11;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_write", 64'(n_writes), 64'(writes_before));
        check("abort_q_empty", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) expect_write(k, prog[k]);
        pulse_start();
        send_word(32'd3, 1'b0);
        send_word(prog[0], 1'b0);
        check("restart_words1", 64'(words_loaded), 64'd1);
        send_word(prog[1], 1'b0);
        send_word(prog[2], 1'b0);
        check_finish("restart", 3);

        // full-depth image
        pulse_start();
        send_word(32'(DEPTH), 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            logic [31:0] w;
            w = $urandom;
            expect_write(k, w);
            send_word(w, 1'b0);
        end
        check("full_last_addr", 64'(imem_addr), 64'(BASE + AW'((DEPTH - 1) * 4)));
        check_finish("full", DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
